sub_pipe_nbit: RTL

//  Two-stage pipelined chained subtractor; the inverse-direction counterpart of the

---
 rtl/sub_pipe_nbit.sv | 104 ++++++++++
 1 files changed

// File: rtl/sub_pipe_nbit.sv
// sub_pipe_nbit: two-stage pipelined chained subtractor with valid/ready on both sides.
//   Stage 1 computes {b1,d1} = in_a - in_b - bin and captures in_c.
//   Stage 2 computes {bout,diff} = d1 - c1 - b1.
// Ports:
//   clk, rst_n                  clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready         input handshake (in_ready is combinational on out_ready)
//   bin, in_a, in_b, in_c       borrow in, minuend, first and second subtrahend
//   out_valid / out_ready       output handshake
//   diff, bout                  registered result and stage-2 borrow out
//   op_count                    wrapping count of completed output handshakes
`timescale 1ns/1ps

module sub_pipe_nbit #(
    parameter int unsigned REG_SIZE = 4,
    parameter int unsigned CNT_SIZE = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                bin,
    input  logic [REG_SIZE-1:0] in_a,
    input  logic [REG_SIZE-1:0] in_b,
    input  logic [REG_SIZE-1:0] in_c,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [REG_SIZE-1:0] diff,
    output logic                bout,
    output logic [CNT_SIZE-1:0] op_count
);

    // One extra bit so the MSB of each difference is the borrow.
    localparam int unsigned EXT_W = REG_SIZE + 1;

    logic                s1_valid;
    logic [REG_SIZE-1:0] s1_d;
    logic [REG_SIZE-1:0] s1_c;
    logic                s1_b;
    logic                s2_valid;

    logic                s1_load;
    logic                s2_load;
    logic                in_fire;
    logic                out_fire;
    logic [EXT_W-1:0]    st1_res;
    logic [EXT_W-1:0]    st2_res;

    // Handshake control and both stage subtractions.
    always_comb begin
        s2_load  = !s2_valid || out_ready;
        s1_load  = !s1_valid || s2_load;
        in_fire  = in_valid && s1_load;
        out_fire = s2_valid && out_ready;
        st1_res  = {1'b0, in_a} - {1'b0, in_b} - EXT_W'(bin);
        st2_res  = {1'b0, s1_d} - {1'b0, s1_c} - EXT_W'(s1_b);
    end

    assign in_ready  = s1_load;
    assign out_valid = s2_valid;

    // Stage 1: data only captured on an accepted input; valid follows in_valid on load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_d     <= '0;
            s1_c     <= '0;
            s1_b     <= 1'b0;
        end else begin
            if (s1_load) begin
                s1_valid <= in_valid;
            end
            if (in_fire) begin
                s1_d <= st1_res[REG_SIZE-1:0];
                s1_b <= st1_res[REG_SIZE];
                s1_c <= in_c;
            end
        end
    end

    // Stage 2: holds result while stalled; a stage-1 bubble clears s2_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            diff     <= '0;
            bout     <= 1'b0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                diff <= st2_res[REG_SIZE-1:0];
                bout <= st2_res[REG_SIZE];
            end
        end
    end

    // Completed-operation counter, wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count <= '0;
        end else if (out_fire) begin
            op_count <= op_count + CNT_SIZE'(1);
        end
    end

endmodule
